// File: rtl/seg7_scan_driver_pkg.sv
`default_nettype none
// ============================================================================
// seg7_scan_driver_pkg : shared segment patterns and FSM encodings
// Revision: 1.0
// ============================================================================
package seg7_scan_driver_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_DEAD  = 2'd1;
  localparam logic [1:0] ST_DRIVE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
`default_nettype none
// ============================================================================
// hex_to_seg7 : combinational nibble to active-low 7-segment pattern
// Revision: 1.0
// ============================================================================
module hex_to_seg7
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// seg7_scan_driver : multiplexed hex display driver with dead time and LZ blanking
// Revision: 1.0
// ============================================================================
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int DEAD_CYCLES = 16,
  parameter int CNT_W       = 8
) (
  input  logic                    clock_in,
  input  logic                    reset,
  input  logic                    scan_clk,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp
);

  localparam int               IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);

  logic [1:0]              state, state_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [4*NUM_DIGITS-1:0] snap, snap_nxt;
  logic [NUM_DIGITS-1:0]   dp_snap, dps_nxt;
  logic                    scan_prev;
  logic                    tick;

  logic [3:0]              nib;
  logic                    dp_bit;
  logic [NUM_DIGITS-1:0]   an_sel;
  logic                    lz_blank;
  logic [6:0]              dec_seg;

  assign tick = scan_clk & ~scan_prev;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    snap_nxt  = snap;
    dps_nxt   = dp_snap;
    if (!enable) begin
      state_nxt = ST_OFF;
      idx_nxt   = IDX_LAST;
      cnt_nxt   = '0;
    end else if (tick) begin
      // A tick from any state advances; digit 0 opens a new frame snapshot
      idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
      if (idx_nxt == '0) begin
        snap_nxt = value;
        dps_nxt  = dp_in;
      end
      cnt_nxt   = '0;
      state_nxt = (DEAD_CYCLES == 0) ? ST_DRIVE : ST_DEAD;
    end else if (state == ST_DEAD) begin
      if (cnt == DEAD_LAST) begin
        state_nxt = ST_DRIVE;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  // Outputs are registered from the next-state view so DRIVE lands with the state change
  always_comb begin
    nib      = 4'h0;
    dp_bit   = 1'b0;
    an_sel   = '1;
    lz_blank = blank_lz && (idx_nxt != '0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_nxt == IDX_W'(i)) begin
        nib       = snap_nxt[4*i +: 4];
        dp_bit    = dps_nxt[i];
        an_sel[i] = 1'b0;
      end
      if ((IDX_W'(i) >= idx_nxt) && (snap_nxt[4*i +: 4] != 4'h0)) begin
        lz_blank = 1'b0;
      end
    end
  end

  hex_to_seg7 u_dec (
    .nibble (nib),
    .seg    (dec_seg)
  );

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state     <= ST_OFF;
      idx       <= IDX_LAST;
      cnt       <= '0;
      snap      <= '0;
      dp_snap   <= '0;
      scan_prev <= 1'b0;
      an        <= '1;
      seg       <= SEG_BLANK;
      dp        <= 1'b1;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      cnt       <= cnt_nxt;
      snap      <= snap_nxt;
      dp_snap   <= dps_nxt;
      scan_prev <= scan_clk;
      if (state_nxt == ST_DRIVE) begin
        an  <= an_sel;
        seg <= lz_blank ? SEG_BLANK : dec_seg;
        dp  <= ~dp_bit;
      end else begin
        an  <= '1;
        seg <= SEG_BLANK;
        dp  <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Multiplexed 4-digit 7-segment display driver.
- Sits directly downstream of the 1 kHz clock divider. It consumes the divided clock as a same-domain level signal (`scan_clk`), never as a clock.
- Each rising edge of `scan_clk` advances one digit, giving a 250 Hz full-display refresh.
- It latches the 16-bit counter value once per frame, inserts anti-ghosting dead time, and drives active-low anodes, segments and decimal point.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; `value` width is 4*NUM_DIGITS.
- DEAD_CYCLES, 16, `clock_in` cycles with all anodes off between digits; 0 is legal.
- CNT_W, 8, width of the dead-time counter; must hold DEAD_CYCLES.

Ports:
- clock_in  input  1  system clock (100 MHz board clock); all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- scan_clk  input  1  1 kHz divided clock from the divider, generated in the `clock_in` domain.
- enable  input  1  display on when high.
- value  input  4*NUM_DIGITS  hex value to show; nibble 0 drives the rightmost digit.
- dp_in  input  NUM_DIGITS  decimal-point request per digit, active high.
- blank_lz  input  1  leading-zero blanking enable.
- an  output  NUM_DIGITS  anode selects, active low, registered.
- seg  output  7  cathodes {g,f,e,d,c,b,a}, active low, registered.
- dp  output  1  decimal-point cathode, active low, registered.

Behaviour:
- Reset values (one cycle after `reset` is sampled high):
  - outputs: `an`=all 1, `seg`=7'h7F, `dp`=1
  - internal: state=OFF, digit index=NUM_DIGITS-1, dead count=0, snapshot=0, `scan_prev`=0.
- Reset mid-operation aborts any dead time or drive immediately.
- Tick generation:
  - `scan_prev` registers `scan_clk`.
  - tick = `scan_clk` & ~`scan_prev`: a single `clock_in` pulse, 1 cycle after the edge is sampled.
  - No synchronizer is needed (same domain).
- States: OFF, DEAD, DRIVE.
- OFF:
  - Outputs blanked.
  - On tick with `enable`=1 → DEAD, with the digit-advance actions below.
- Digit advance (on a tick taken in any state while `enable`=1):
  - index ← index+1, wrapping NUM_DIGITS-1 → 0.
  - If the new index is 0, snapshot ← `value` and dp snapshot ← `dp_in`.
  - dead count ← 0.
  - Outputs blanked in the next cycle.
- DEAD:
  - Outputs blanked; dead count increments each cycle.
  - When dead count = DEAD_CYCLES-1 → DRIVE.
  - If DEAD_CYCLES=0, go from the advance straight to DRIVE (no blank cycle).
- DRIVE:
  - `an`[index]=0 and all other anodes 1.
  - `seg` = hex decode of snapshot nibble[index]; `dp` = ~dp snapshot[index].
  - Held until the next tick.
- Tick during DEAD: restart dead time and advance again; no digit is skipped from the frame's snapshot.
- `enable` falling: next cycle → OFF, outputs blanked, index ← NUM_DIGITS-1. Re-enable waits for the next tick, which starts at digit 0 with a fresh snapshot.
- Leading-zero blanking:
  - When `blank_lz`=1 and index≠0, digit i is blanked (`seg`=7'h7F, anode still driven) if snapshot nibbles i..NUM_DIGITS-1 are all zero.
  - Digit 0 always shows.
  - `dp` is unaffected.
- Decode, active low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Tearing: `value` changes mid-frame are not visible until the next digit-0 advance.
- Output latency: decode and anode are registered. DRIVE outputs appear DEAD_CYCLES+1 cycles after the tick pulse.

Decomposition:
- Shared package/include:
  - SEG_BLANK=7'h7F
  - the 16-entry hex pattern constants
  - state encodings OFF/DEAD/DRIVE (2-bit)
- One sub-module: `hex_to_seg7` (4-bit nibble → 7-bit active-low pattern, purely combinational), reused by the counter top level.
- FSM, tick detect, snapshot and blanking logic stay in `seg7_scan_driver`.

Test Plan:
- Reset: hold `reset` for 3 cycles with `scan_clk` toggling → `an`=4'hF, `seg`=7'h7F, `dp`=1 throughout and one cycle after release.
- Basic scan:
  - Setup: `value`=16'h12AF, DEAD_CYCLES=16, `enable`=1, `scan_clk` at 1 kHz.
  - Successive DRIVE windows: `an`=1110/`seg`=0E, 1101/08, 1011/24, 0111/79, then wrap to 1110.
  - Each window is preceded by exactly 16 cycles of `an`=4'hF.
- Leading zeros: `value`=16'h0070, `blank_lz`=1 → digits 3 and 2 show `seg`=7F with their anode low; digit 1 shows 78; digit 0 shows 40.
  - With `blank_lz`=0, digits 3 and 2 show 40.
- Snapshot: change `value` from 16'h1111 to 16'h2222 while digit 2 is driven → digit 3 still shows 79; the next frame shows 24 on all digits.
- Enable/DP: set `dp_in`=4'b0100 → `dp`=0 only while `an`=1011. Drop `enable` mid-DEAD → blanked the next cycle. Re-enable → first drive is digit 0 with `an`=1110.
- DEAD_CYCLES=0 variant: the DRIVE pattern appears 1 cycle after the tick pulse, with no all-off cycle.
